lcd_cmd_sched: RTL and testbench

- Command scheduler in front of the image display controller (8x8 image, commands 0–11, busy/done handshake).
- Buffers host commands in a small FIFO and drops illegal opcodes.
- Issues one command at a time to the display controller, only when that controller is ready.
- Tracks Write (frame output) completion and reports status and counters to the host.

---
 rtl/lcd_cmd_sched.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_cmd_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sched.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sched
//
// Command scheduler in front of the 8x8 image display controller. Host
// opcodes (0..11) are buffered in a small FIFO, and illegal opcodes (12..15)
// are dropped. Commands go to the controller one at a time, and only while it
// is not busy. Completion of Write (opcode 0) frame outputs is tracked and
// reported to the host.
//
// Handshake (host side): a transfer happens on a rising clk edge when
// host_valid and host_ready are both high. host_ready depends only on FIFO
// fullness, never on host_valid. lcd_cmd_valid is a one-cycle issue strobe
// with no back-pressure; the controller signals progress through lcd_busy
// and lcd_done.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   host_cmd        4-bit opcode from host
//   host_valid      host_cmd valid
//   host_ready      FIFO can accept (= !full)
//   flush           synchronous FIFO clear (also clears err_illegal)
//   lcd_cmd         last issued opcode (held between issues)
//   lcd_cmd_valid   one-cycle issue strobe
//   lcd_busy        display controller busy
//   lcd_done        display controller frame-output-complete pulse
//   frame_done      one-cycle pulse per completed Write
//   q_count         current FIFO occupancy
//   issued_cnt      commands issued since reset (wraps)
//   err_illegal     sticky: an opcode 12..15 was accepted
//   dbg_state       current FSM state (0 INIT, 1 IDLE, 2 GUARD,
//                   3 WAIT_RDY, 4 WAIT_DONE)
// ---------------------------------------------------------------------------
module lcd_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     flush,
    output logic [3:0]               lcd_cmd,
    output logic                     lcd_cmd_valid,
    input  logic                     lcd_busy,
    input  logic                     lcd_done,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic                     err_illegal,
    output logic [2:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE  = 1;
    localparam logic [AW:0]      DEPTH_L  = DEPTH[AW:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_GUARD     = 3'd2,
        ST_WAIT_RDY  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        mem_q [DEPTH];
    logic [3:0]        mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [3:0]        lcd_cmd_q, lcd_cmd_d;
    logic              lcd_cmd_valid_q, lcd_cmd_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
    logic              err_illegal_q, err_illegal_d;

    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic [3:0]        head;
    logic              accept;
    logic              push;
    logic              illegal_seen;
    logic              issue;

    // Pointers carry one extra wrap bit, so equal low bits with different
    // wrap bits means full.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_L);
    assign empty        = (count == '0);
    assign head         = mem_q[rd_ptr_q[AW-1:0]];

    assign host_ready   = !full;
    assign accept       = host_valid && host_ready;
    assign push         = accept && (host_cmd < 4'd12) && !flush;
    assign illegal_seen = accept && (host_cmd >= 4'd12);

    // Issue decision shares the FSM's IDLE state. A flush cycle never pops,
    // so a flush cannot race with an issue.
    assign issue        = (state_q == ST_IDLE) && !empty && !lcd_busy && !flush;

    // ---------------- FIFO and status datapath ----------------
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        err_illegal_d = err_illegal_q | illegal_seen;
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            err_illegal_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = host_cmd;
                wr_ptr_d                = wr_ptr_q + PTR_ONE;
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:      if (!lcd_busy) state_d = ST_IDLE;
            ST_IDLE:      if (issue)     state_d = ST_GUARD;
            // lcd_busy is ignored here: the controller needs a cycle to
            // raise busy after seeing the strobe.
            ST_GUARD:     state_d = (lcd_cmd_q == 4'd0) ? ST_WAIT_DONE : ST_WAIT_RDY;
            ST_WAIT_RDY:  if (!lcd_busy) state_d = ST_IDLE;
            ST_WAIT_DONE: if (lcd_done)  state_d = ST_WAIT_RDY;
            default:      state_d = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        lcd_cmd_d       = lcd_cmd_q;
        lcd_cmd_valid_d = 1'b0;
        issued_cnt_d    = issued_cnt_q;
        frame_done_d    = 1'b0;
        if (issue) begin
            lcd_cmd_d       = head;
            lcd_cmd_valid_d = 1'b1;
            issued_cnt_d    = issued_cnt_q + CNT_ONE;
        end
        if ((state_q == ST_WAIT_DONE) && lcd_done) begin
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_cmd_q       <= '0;
            lcd_cmd_valid_q <= 1'b0;
            issued_cnt_q    <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            lcd_cmd_q       <= lcd_cmd_d;
            lcd_cmd_valid_q <= lcd_cmd_valid_d;
            issued_cnt_q    <= issued_cnt_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = lcd_cmd_valid_q;
    assign frame_done    = frame_done_q;
    assign issued_cnt    = issued_cnt_q;
    assign err_illegal   = err_illegal_q;
    assign q_count       = count;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_sched
//
// Bench for lcd_cmd_sched (DEPTH=8, CNT_W=16). A vector table covers FIFO
// fill, the full boundary, illegal filtering and flush. Hand-written
// sequences cover init gating, Write completion, flush during an in-flight
// Write, and asynchronous reset. A negedge monitor compares every issued
// opcode against the expected queue exp_q.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_sched;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [3:0]       host_cmd;
    logic             host_valid;
    logic             host_ready;
    logic             flush;
    logic [3:0]       lcd_cmd;
    logic             lcd_cmd_valid;
    logic             lcd_busy;
    logic             lcd_done;
    logic             frame_done;
    logic [3:0]       q_count;
    logic [CNT_W-1:0] issued_cnt;
    logic             err_illegal;
    logic [2:0]       dbg_state;

    lcd_cmd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .flush         (flush),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .frame_done    (frame_done),
        .q_count       (q_count),
        .issued_cnt    (issued_cnt),
        .err_illegal   (err_illegal),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required finish before limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int n_issue = 0;
    int last_issue_cyc = 0;
    int fd_cnt = 0;
    logic prev_valid = 1'b0;
    logic [3:0] mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            n_issue    = 0;
        end else begin
            if (lcd_cmd_valid) begin
                chk("no_back_to_back_valid", int'(prev_valid), 0);
                if (n_issue > 0) chk("issue_spacing_ge3", int'((cyc - last_issue_cyc) >= 3), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got lcd_cmd=%0d, expected no issue (t=%0t)", lcd_cmd, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("issue_order", int'(lcd_cmd), int'(mon_exp));
                end
                last_issue_cyc = cyc;
                n_issue++;
            end
            if (frame_done) fd_cnt++;
            prev_valid = lcd_cmd_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        host_valid = 1'b0;
        flush      = 1'b0;
        lcd_done   = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Only used where the bench knows the FIFO has room.
    task automatic push(input logic [3:0] cmd);
        host_cmd   = cmd;
        host_valid = 1'b1;
        if (cmd < 4'd12) exp_q.push_back(cmd);
        tick();
        host_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_host_ready"},    int'(host_ready),    1);
        chk({tag, "_lcd_cmd"},       int'(lcd_cmd),       0);
        chk({tag, "_lcd_cmd_valid"}, int'(lcd_cmd_valid), 0);
        chk({tag, "_frame_done"},    int'(frame_done),    0);
        chk({tag, "_q_count"},       int'(q_count),       0);
        chk({tag, "_issued_cnt"},    int'(issued_cnt),    0);
        chk({tag, "_err_illegal"},   int'(err_illegal),   0);
        chk({tag, "_state_init"},    int'(dbg_state),     0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] cmd;
        logic       vld;
        logic       fl;
        logic [3:0] exp_cnt;
        logic       exp_rdy;
        logic       exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    // ---------------- main test ----------------
    initial begin
        int fd_base;
        logic prev_rdy;

        // cmd, vld, flush | q_count, host_ready, err_illegal (after the edge)
        vecs[0]  = '{4'd12, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
        vecs[1]  = '{4'd4,  1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[2]  = '{4'd15, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[3]  = '{4'd7,  1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
        vecs[4]  = '{4'd9,  1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'd3,  1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[6]  = '{4'd11, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'd2,  1'b1, 1'b0, 4'd4, 1'b1, 1'b0};
        vecs[8]  = '{4'd6,  1'b1, 1'b0, 4'd5, 1'b1, 1'b0};
        vecs[9]  = '{4'd10, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0};
        vecs[10] = '{4'd5,  1'b1, 1'b0, 4'd7, 1'b1, 1'b0};
        vecs[11] = '{4'd1,  1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[12] = '{4'd7,  1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[13] = '{4'd13, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[14] = '{4'd0,  1'b0, 1'b0, 4'd8, 1'b0, 1'b0};

        reset      = 1'b1;
        host_cmd   = '0;
        host_valid = 1'b0;
        flush      = 1'b0;
        lcd_busy   = 1'b1;
        lcd_done   = 1'b0;

        // Reset state, before any clock edge.
        #2;
        chk_reset_vals("rst0");

        // ---- init gating: busy held 70 cycles, then 1 and 3 issue ----
        do_reset();
        push(4'd1);
        push(4'd3);
        repeat (68) tick();
        chk("init_no_issue", exp_q.size(), 2);
        chk("init_state", int'(dbg_state), 0);
        chk("init_q_count", int'(q_count), 2);
        lcd_busy = 1'b0;
        wait_drain("init_drain", 50);
        repeat (4) tick();
        chk("init_issued_cnt", int'(issued_cnt), 2);
        chk("init_lcd_cmd_held", int'(lcd_cmd), 3);

        // ---- table: illegal filter, flush, full FIFO (busy holds INIT) ----
        lcd_busy = 1'b1;
        do_reset();
        prev_rdy = 1'b1;
        for (int i = 0; i < NV; i++) begin
            host_cmd   = vecs[i].cmd;
            host_valid = vecs[i].vld;
            flush      = vecs[i].fl;
            if (vecs[i].fl) exp_q.delete();
            else if (vecs[i].vld && prev_rdy && vecs[i].cmd < 4'd12) exp_q.push_back(vecs[i].cmd);
            tick();
            chk($sformatf("vec%0d_q_count", i),     int'(q_count),     int'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_host_ready", i),  int'(host_ready),  int'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_err_illegal", i), int'(err_illegal), int'(vecs[i].exp_err));
            prev_rdy = vecs[i].exp_rdy;
        end
        host_valid = 1'b0;
        flush      = 1'b0;
        lcd_busy   = 1'b0;
        wait_drain("full_drain", 100);
        repeat (4) tick();
        chk("full_issued_cnt", int'(issued_cnt), 8);
        chk("full_q_empty", int'(q_count), 0);

        // ---- Write sequencing: 0 then 5 ----
        lcd_busy = 1'b0;
        do_reset();
        tick();
        push(4'd0);
        push(4'd5);
        chk("wr_issue_strobe", int'(lcd_cmd_valid), 1);
        chk("wr_issue_opcode", int'(lcd_cmd), 0);
        lcd_busy = 1'b1;
        fd_base  = fd_cnt;
        repeat (64) tick();
        chk("wr_wait_done_state", int'(dbg_state), 4);
        chk("wr_5_held", exp_q.size(), 1);
        lcd_done = 1'b1;
        chk("wr_fd_before", int'(frame_done), 0);
        tick();
        lcd_done = 1'b0;
        chk("wr_fd_pulse", int'(frame_done), 1);
        tick();
        chk("wr_fd_one_cycle", int'(frame_done), 0);
        repeat (5) tick();
        chk("wr_5_waits_busy", exp_q.size(), 1);
        lcd_busy = 1'b0;
        wait_drain("wr_drain", 20);
        repeat (4) tick();
        chk("wr_issued_cnt", int'(issued_cnt), 2);
        chk("wr_fd_count", fd_cnt - fd_base, 1);

        // ---- illegal filter: 12, 4, 15 then flush clears error ----
        do_reset();
        tick();
        push(4'd12);
        chk("ill_err_set", int'(err_illegal), 1);
        chk("ill_q0", int'(q_count), 0);
        push(4'd4);
        chk("ill_q1", int'(q_count), 1);
        push(4'd15);
        chk("ill_q_after15", int'(q_count), 0);
        wait_drain("ill_drain", 20);
        repeat (10) tick();
        chk("ill_err_sticky", int'(err_illegal), 1);
        chk("ill_issued_cnt", int'(issued_cnt), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ill_flush_clears", int'(err_illegal), 0);

        // ---- flush during in-flight Write ----
        do_reset();
        tick();
        fd_base = fd_cnt;
        push(4'd0);
        push(4'd1);
        push(4'd2);
        chk("fl_wait_done_state", int'(dbg_state), 4);
        chk("fl_q_before", int'(q_count), 2);
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        chk("fl_q_after", int'(q_count), 0);
        chk("fl_state_kept", int'(dbg_state), 4);
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        chk("fl_fd_pulse", int'(frame_done), 1);
        repeat (20) tick();
        chk("fl_issued_cnt", int'(issued_cnt), 1);
        chk("fl_fd_count", fd_cnt - fd_base, 1);

        // ---- asynchronous reset mid-WAIT_DONE ----
        do_reset();
        tick();
        push(4'd0);
        push(4'd7);
        tick();
        chk("rs_wait_done_state", int'(dbg_state), 4);
        chk("rs_q_before", int'(q_count), 1);
        lcd_busy = 1'b1;
        reset    = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_vals("rs_async");
        tick();
        tick();
        reset = 1'b0;
        fd_base  = fd_cnt;
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        chk("rs_stale_done_fd", int'(frame_done), 0);
        tick();
        chk("rs_stale_done_fd2", int'(frame_done), 0);
        chk("rs_state_init", int'(dbg_state), 0);
        lcd_busy = 1'b0;
        repeat (20) tick();
        chk("rs_issued_cnt", int'(issued_cnt), 0);
        chk("rs_q_lost", int'(q_count), 0);
        chk("rs_fd_count", fd_cnt - fd_base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
